// File: rtl/cipher_sequencer.sv
// Message-level cipher controller. It buffers a message and a repeating key,
// then streams the message one letter per cycle through a mod-26 shift stage.
module cipher_sequencer #(
    parameter int MSG_DEPTH = 16,
    parameter int KEY_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [4:0]                     char_in,
    input  logic                           char_load,
    input  logic                           msg_clear,
    input  logic [4:0]                     key_in,
    input  logic                           key_load,
    input  logic                           key_clear,
    input  logic                           decode,
    input  logic [1:0]                     method,
    input  logic                           go,
    output logic                           busy,
    output logic                           done,
    output logic                           out_valid,
    output logic [4:0]                     out_char,
    output logic [$clog2(MSG_DEPTH)-1:0]   out_idx,
    output logic [$clog2(MSG_DEPTH):0]     msg_count,
    output logic                           err
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int KW = $clog2(KEY_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [4:0]    msg_mem [MSG_DEPTH];
    logic [4:0]    key_mem [KEY_DEPTH];
    logic [KW:0]   key_count;
    logic [AW-1:0] rd_idx;
    logic [KW-1:0] kptr;
    logic [KW:0]   kptr_inc;
    logic          mode_decode;
    logic [1:0]    mode_method;

    logic          in_idle;
    logic          idle_cmd;
    logic          start;
    logic          char_ok;
    logic          key_ok;
    logic          msg_write;
    logic          msg_reject;
    logic          key_write;
    logic          key_reject;
    logic          last_read;
    logic          reserved_go;

    logic [4:0]    cur_key;
    logic [5:0]    c6;
    logic [5:0]    k6;
    logic [5:0]    sum6;
    logic [4:0]    result;

    // Command decode: go wins over every load/clear, clears win over loads.
    // The buffer is full exactly when the count's top bit is set.
    always_comb begin
        in_idle     = (state == IDLE);
        start       = in_idle && go;
        idle_cmd    = in_idle && !go;
        char_ok     = (char_in <= 5'd25);
        key_ok      = (key_in <= 5'd25);
        msg_write   = idle_cmd && !msg_clear && char_load && char_ok && !msg_count[AW];
        msg_reject  = idle_cmd && !msg_clear && char_load && (!char_ok || msg_count[AW]);
        key_write   = idle_cmd && !key_clear && key_load && key_ok && !key_count[KW];
        key_reject  = idle_cmd && !key_clear && key_load && (!key_ok || key_count[KW]);
        last_read   = ({1'b0, rd_idx} == (msg_count - {{AW{1'b0}}, 1'b1}));
        reserved_go = start && (msg_count != '0) && (method == 2'b11);
        kptr_inc    = {1'b0, kptr} + {{KW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = (msg_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_read) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // Buffer storage carries no reset; only the counts define what is valid.
    always_ff @(posedge clk) begin
        if (msg_write) begin
            msg_mem[msg_count[AW-1:0]] <= char_in;
        end
        if (key_write) begin
            key_mem[key_count[KW-1:0]] <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_count <= '0;
            key_count <= '0;
            err       <= 1'b0;
        end else begin
            if (idle_cmd && msg_clear) begin
                msg_count <= '0;
            end else if (msg_write) begin
                msg_count <= msg_count + {{AW{1'b0}}, 1'b1};
            end

            if (idle_cmd && key_clear) begin
                key_count <= '0;
            end else if (key_write) begin
                key_count <= key_count + {{KW{1'b0}}, 1'b1};
            end

            if (msg_reject || key_reject || reserved_go) begin
                err <= 1'b1;
            end else if (idle_cmd && msg_clear) begin
                err <= 1'b0;
            end
        end
    end

    // Key selection: an empty key buffer means a zero shift for every method.
    always_comb begin
        cur_key = 5'd0;
        if (key_count != '0) begin
            case (mode_method)
                2'b01:   cur_key = key_mem[0];
                2'b10:   cur_key = key_mem[kptr];
                default: cur_key = 5'd0;
            endcase
        end
    end

    always_comb begin
        c6   = {1'b0, msg_mem[rd_idx]};
        k6   = {1'b0, cur_key};
        sum6 = c6 + k6;
        if (mode_decode) begin
            result = (c6 < k6) ? 5'(c6 + 6'd26 - k6) : 5'(c6 - k6);
        end else begin
            result = (sum6 >= 6'd26) ? 5'(sum6 - 6'd26) : 5'(sum6);
        end
    end

    // Reserved method is latched as pass so the shift stage never sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx      <= '0;
            kptr        <= '0;
            mode_decode <= 1'b0;
            mode_method <= 2'b00;
            out_valid   <= 1'b0;
            out_char    <= 5'd0;
            out_idx     <= '0;
        end else begin
            out_valid <= (state == RUN);
            if (start) begin
                rd_idx      <= '0;
                kptr        <= '0;
                mode_decode <= decode;
                mode_method <= (method == 2'b11) ? 2'b00 : method;
            end else if (state == RUN) begin
                out_char <= result;
                out_idx  <= rd_idx;
                rd_idx   <= rd_idx + {{(AW-1){1'b0}}, 1'b1};
                kptr     <= (kptr_inc == key_count) ? '0 : kptr_inc[KW-1:0];
            end
        end
    end

endmodule
